// File: rtl/mux2_rr_arbiter.sv
// Two-source valid/ready arbiter feeding one registered output stage, round-robin on contention.
// Build option: define MUX2_ARB_FIXED_PRIO_EN for fixed priority (a always wins, b may starve).
module mux2_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  logic             out_valid_q;
  logic             out_sel_q;
  logic [WIDTH-1:0] out_data_q;

  logic             load_en;
  logic             grant_valid;
  logic             grant_idx;
  logic             accept;

  // The output register can take a new beat when empty or being drained this cycle.
  assign load_en = !out_valid_q || out_ready;

`ifdef MUX2_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_valid = a_valid || b_valid;
    grant_idx   = !a_valid;
  end
`else
  logic last_grant_q;

  always_comb begin
    grant_valid = a_valid || b_valid;
    if (a_valid && b_valid) begin
      grant_idx = !last_grant_q;
    end else begin
      grant_idx = !a_valid;
    end
  end

  // Priority only moves on a real grant, so an idle source never shifts the turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (load_en && grant_valid) begin
      last_grant_q <= grant_idx;
    end
  end
`endif

  assign accept  = !rst && load_en && grant_valid;
  assign a_ready = accept && !grant_idx;
  assign b_ready = accept && grant_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sel_q   <= 1'b0;
      out_data_q  <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid_q <= 1'b1;
        out_sel_q   <= grant_idx;
        out_data_q  <= grant_idx ? b_data : a_data;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed test-plan steps, then randomized
// traffic checked cycle by cycle against a transaction-level reference model.
module tb_mux2_rr_arbiter;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, b_valid, out_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready, out_valid, out_sel;
  logic [WIDTH-1:0] out_data;

  mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: what the output register should hold, and who was served last.
  bit             m_valid;
  bit [WIDTH-1:0] m_data;
  bit             m_sel;
  bit             m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check readies mid-cycle, advance the model, check the output register.
  task automatic step(output bit took_a, output bit took_b);
    bit can_load, have, pick;
    @(negedge clk);
    can_load = !m_valid || out_ready;
    have     = a_valid || b_valid;
    if (a_valid && b_valid) begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
      pick = 1'b0;
`else
      pick = (m_last == 1'b0);
`endif
    end else begin
      pick = b_valid;
    end
    took_a = !rst && can_load && have && !pick;
    took_b = !rst && can_load && have && pick;
    chk("a_ready", a_ready, took_a);
    chk("b_ready", b_ready, took_b);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_last = 1;
    end else if (took_a || took_b) begin
      m_valid = 1;
      m_sel   = took_b;
      m_data  = took_b ? b_data : a_data;
      m_last  = took_b;
    end else if (can_load) begin
      m_valid = 0;
    end
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_sel", out_sel, m_sel);
  endtask

  initial begin
    bit ta, tb_;
    bit [WIDTH-1:0] qa[$];
    bit [WIDTH-1:0] qb[$];
    logic [3:0] seq_sel;
    logic [3:0] seq_dat_b;
    logic       rel_sel;
    logic [7:0] rel_data;

`ifdef MUX2_ARB_FIXED_PRIO_EN
    seq_sel  = 4'b0000;
    rel_sel  = 1'b0;
    rel_data = 8'h11;
`else
    seq_sel  = 4'b1010;
    rel_sel  = 1'b1;
    rel_data = 8'h22;
`endif
    seq_dat_b = seq_sel;

    // Reset held 2 cycles with both sources valid.
    rst = 1; a_valid = 1; b_valid = 1; a_data = 8'h11; b_data = 8'h22; out_ready = 1;
    m_valid = 0; m_data = '0; m_sel = 0; m_last = 1;
    step(ta, tb_);
    step(ta, tb_);
    rst = 0;

    // Contention with out_ready high: alternation begins with a.
    for (int i = 0; i < 4; i++) begin
      step(ta, tb_);
      chk("cont_sel", out_sel, seq_sel[i]);
      chk("cont_data", out_data, seq_dat_b[i] ? 8'h22 : 8'h11);
`ifdef MUX2_ARB_FIXED_PRIO_EN
      chk("fixed_b_ready", tb_, 0);
`endif
    end

    // Load an a beat, then backpressure for 3 cycles.
`ifndef MUX2_ARB_FIXED_PRIO_EN
    step(ta, tb_);
    chk("bp_load_sel", out_sel, 0);
`endif
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(ta, tb_);
      chk("bp_hold_data", out_data, 8'h11);
      chk("bp_hold_sel", out_sel, 0);
    end
    out_ready = 1;
    step(ta, tb_);
    chk("bp_release_sel", out_sel, rel_sel);
    chk("bp_release_data", out_data, rel_data);

    // Single source b, then idle: output drains.
    a_valid = 0; b_valid = 1; b_data = 8'h5A;
    step(ta, tb_);
    chk("single_5A", out_data, 8'h5A);
    b_data = 8'h5B;
    step(ta, tb_);
    chk("single_5B", out_data, 8'h5B);
    chk("single_sel", out_sel, 1);
    b_valid = 0;
    step(ta, tb_);
    chk("drain_valid", out_valid, 0);
    a_valid = 1; b_valid = 1; a_data = 8'h11; b_data = 8'h22;
    step(ta, tb_);
    chk("after_idle_sel", out_sel, 0);

    // Mid-stream reset discards the held beat; a wins afterwards.
    step(ta, tb_);
    rst = 1;
    step(ta, tb_);
    chk("midrst_valid", out_valid, 0);
    rst = 0;
    step(ta, tb_);
    chk("midrst_restart_sel", out_sel, 0);

    // Randomized traffic: sources are queues that hold a beat until it is accepted.
    a_valid = 0; b_valid = 0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 2) == 0) qa.push_back(WIDTH'($urandom));
      if ($urandom_range(0, 2) == 0) qb.push_back(WIDTH'($urandom));
      a_valid   = qa.size() > 0;
      b_valid   = qb.size() > 0;
      a_data    = a_valid ? qa[0] : WIDTH'($urandom);
      b_data    = b_valid ? qb[0] : WIDTH'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      rst       = $urandom_range(0, 99) == 0;
      step(ta, tb_);
      if (ta) void'(qa.pop_front());
      if (tb_) void'(qb.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
